mc_datapath: RTL

MC_DATAPATH -- requirements
Module: mc_datapath

---
 rtl/mc_datapath_pkg.sv | 42 ++++
 rtl/mc_datapath_regfile.sv | 30 +++
 rtl/mc_datapath.sv | 115 +++++++++++
 3 files changed

// File: rtl/mc_datapath_pkg.sv
// Shared widths, control encodings and helpers for the multicycle datapath.
package mc_datapath_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_AW    = $clog2(RF_DEPTH);
  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned SEL_W    = 2;
  localparam int unsigned IMM_W    = 16;

  typedef logic [ALUCTL_W-1:0] aluctl_t;
  typedef logic [SEL_W-1:0]    sel_t;
  typedef logic [DATA_W-1:0]   word_t;

  // ALU operation codes
  localparam aluctl_t ALU_AND = 4'b0000;
  localparam aluctl_t ALU_OR  = 4'b0001;
  localparam aluctl_t ALU_ADD = 4'b0010;
  localparam aluctl_t ALU_SUB = 4'b0110;
  localparam aluctl_t ALU_SLT = 4'b0111;
  localparam aluctl_t ALU_NOR = 4'b1100;

  // ALU B-operand selects
  localparam sel_t SRCB_REG   = 2'b00;
  localparam sel_t SRCB_FOUR  = 2'b01;
  localparam sel_t SRCB_IMM   = 2'b10;
  localparam sel_t SRCB_IMMSH = 2'b11;

  // Next-PC selects
  localparam sel_t PC_ALU    = 2'b00;
  localparam sel_t PC_ALUOUT = 2'b01;
  localparam sel_t PC_JUMP   = 2'b10;
  localparam sel_t PC_HOLD   = 2'b11;

  localparam word_t RESET_PC = '0;

  // Sign-extend a 16-bit immediate to the datapath width
  function automatic word_t sign_ext(input logic [IMM_W-1:0] imm);
    return {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
  endfunction

endpackage

// File: rtl/mc_datapath_regfile.sv
// 32x32 register file: two combinational reads, one clocked write, $0 hardwired to zero.
module regfile
  import mc_datapath_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [RF_AW-1:0] ra1,
  input  logic [RF_AW-1:0] ra2,
  input  logic [RF_AW-1:0] wa,
  input  word_t            wd,
  output word_t            rd1,
  output word_t            rd2
);

  word_t mem [RF_DEPTH];

  // Clocked write; writes to $0 are dropped, contents are never reset
  always_ff @(posedge clk) begin
    if (we && (wa != '0)) begin
      mem[wa] <= wd;
    end
  end

  // Combinational reads see the pre-edge contents (no write bypass)
  always_comb begin
    rd1 = (ra1 == '0) ? '0 : mem[ra1];
    rd2 = (ra2 == '0) ? '0 : mem[ra2];
  end

endmodule

// File: rtl/mc_datapath.sv
// Multicycle MIPS-style datapath: PC/IR/MDR/A/B/ALUOut, inline ALU, register file.
module mc_datapath
  import mc_datapath_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                pcen,
  input  logic                irwrite,
  input  logic                regwrite,
  input  logic                alusrca,
  input  logic                iord,
  input  logic                memtoreg,
  input  logic                regdst,
  input  logic [SEL_W-1:0]    alusrcb,
  input  logic [SEL_W-1:0]    pcsrc,
  input  logic [ALUCTL_W-1:0] alucontrol,
  input  logic [DATA_W-1:0]   readdata,
  output logic [DATA_W-1:0]   adr,
  output logic [DATA_W-1:0]   writedata,
  output logic [5:0]          op,
  output logic [5:0]          funct,
  output logic                zero
);

  word_t pc, ir, mdr, a, b, aluout;
  word_t rd1, rd2;
  word_t srca, srcb, aluresult, pcnext, signimm, wd;
  logic [RF_AW-1:0] wa;

  // Architectural state; everything except PC/IR reloads every cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc     <= RESET_PC;
      ir     <= '0;
      mdr    <= '0;
      a      <= '0;
      b      <= '0;
      aluout <= '0;
    end else begin
      if (pcen)    pc <= pcnext;
      if (irwrite) ir <= readdata;
      mdr    <= readdata;
      a      <= rd1;
      b      <= rd2;
      aluout <= aluresult;
    end
  end

  // Register-file write address and data selection
  always_comb begin
    wa = regdst   ? ir[15:11] : ir[20:16];
    wd = memtoreg ? mdr       : aluout;
  end

  regfile u_regfile (
    .clk (clk),
    .we  (regwrite),
    .ra1 (ir[25:21]),
    .ra2 (ir[20:16]),
    .wa  (wa),
    .wd  (wd),
    .rd1 (rd1),
    .rd2 (rd2)
  );

  // ALU operand muxes
  always_comb begin
    signimm = sign_ext(ir[IMM_W-1:0]);
    srca    = alusrca ? a : pc;
    srcb    = b;
    case (alusrcb)
      SRCB_REG:   srcb = b;
      SRCB_FOUR:  srcb = DATA_W'(4);
      SRCB_IMM:   srcb = signimm;
      SRCB_IMMSH: srcb = {signimm[DATA_W-3:0], 2'b00};
      default:    srcb = b;
    endcase
  end

  // ALU: modulo-2^32 arithmetic, signed SLT, unknown codes give zero
  always_comb begin
    aluresult = '0;
    case (alucontrol)
      ALU_AND: aluresult = srca & srcb;
      ALU_OR:  aluresult = srca | srcb;
      ALU_ADD: aluresult = srca + srcb;
      ALU_SUB: aluresult = srca - srcb;
      ALU_SLT: aluresult = {{(DATA_W-1){1'b0}}, ($signed(srca) < $signed(srcb))};
      ALU_NOR: aluresult = ~(srca | srcb);
      default: aluresult = '0;
    endcase
  end

  // Next-PC selection; PC_HOLD recirculates the current PC
  always_comb begin
    pcnext = pc;
    case (pcsrc)
      PC_ALU:    pcnext = aluresult;
      PC_ALUOUT: pcnext = aluout;
      PC_JUMP:   pcnext = {pc[31:28], ir[25:0], 2'b00};
      PC_HOLD:   pcnext = pc;
      default:   pcnext = pc;
    endcase
  end

  // Controller-facing and memory-facing outputs, combinational by design
  always_comb begin
    adr       = iord ? aluout : pc;
    writedata = b;
    op        = ir[31:26];
    funct     = ir[5:0];
    zero      = (aluresult == '0);
  end

endmodule
